dcpu_core_hs: RTL
=================

// Module: dcpu_core_hs
// PURPOSE
// - Parametrised next-generation accumulator CPU core: same ISA encoding as the first dCPU,
//   generic data/address width, explicit named-state FSM, req/ack memory handshake with
//   arbitrary wait states, N/V flags and illegal-opcode trap.
// - Sits between the top level and a single shared memory/MMIO port.
// PARAMETERS
// - DATA_W     16     accumulator, operand and memory data width (>=8)
// - ADDR_W     16     pc, sp and memory address width
// - IB         2      byte stride per memory word; pc/sp step size
// - PC_START   0      pc value after reset
// - SP_START   254    sp value after reset (points at next free slot)
// PORTS
// - clk        in   1       clock, all state updates on posedge
// - rst        in   1       reset, asynchronous, active-high
// - mem_req    out  1       transaction request; held with addr/we/wdata stable until ack
// - mem_we     out  1       1=write, 0=read; valid while mem_req
// - mem_addr   out  ADDR_W  transaction address
// - mem_wdata  out  DATA_W  write data (acc or return pc, zero-extended)
// - mem_rdata  in   DATA_W  read data, sampled on posedge where mem_req&mem_ack
// - mem_ack    in   1       completes current transaction this edge (any latency >=0 waits)
// - halted     out  1       core stopped (STOP or illegal opcode); sticky until rst
// - illegal    out  1       halt cause was an undefined opcode; sticky until rst
// - flags      out  4       {V,N,C,Z}
// - acc_dbg    out  DATA_W  accumulator (debug)
// BEHAVIOUR
// - Reset: pc=PC_START, sp=SP_START, acc=0, flags=0, state=FETCH, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, halted=0, illegal=0. Async rst mid-transaction drops mem_req at once.
// - Opcodes (low 8 bits, upper bits ignored): LITA c0, LOADA c1, STORA c2, ADD c3, JMP c4, JMPZ c5,
//   JMPC c6, SUB c7, CMP c8, JMPNC c9, PUSH ca, POP cb, STOP cc, CALL cd, RET ce, NOP 90.
// - One-word instrs: NOP STOP PUSH POP RET; all others opcode word + operand word at pc+IB.
// - States: FETCH (read ir@pc) -> DECODE -> OPND (read op@pc+IB, two-word only) -> EXEC
//   -> MEM (data access, if needed) -> FETCH; HALT absorbing. A read/write state waits while
//   mem_ack=0; advances on the edge with mem_ack=1. No zero-cycle transactions.
// - Semantics (pc_n = pc + IB*words):
//   LITA acc=op | ADD acc=acc+op | SUB acc=acc-op | CMP flags only, as SUB
//   LOADA acc=M[op] | STORA M[op]=acc | JMP pc=op | JMPZ/JMPC/JMPNC pc=op if Z / C / !C else pc_n
//   PUSH M[sp]=acc, sp-=IB | POP sp+=IB, acc=M[sp] | CALL M[sp]=pc_n, sp-=IB, pc=op
//   RET sp+=IB, pc=M[sp] (low ADDR_W bits) | NOP pc=pc_n | STOP -> HALT, halted=1
// - Flags updated only by ADD/SUB/CMP: Z=(res==0); N=res[MSB]; ADD C=carry-out; SUB/CMP C=no
//   borrow (acc>=op unsigned); V=signed overflow. Arithmetic modulo 2^DATA_W.
// - Jump condition uses flags as held at EXEC entry.
// - pc and sp wrap modulo 2^ADDR_W; no stack-overflow detection.
// - Undefined opcode in DECODE: halted=1, illegal=1, pc left pointing at offending word.
// - In HALT mem_req=0 forever; only rst exits.
// - Minimum latency, zero wait: 1-word 3 cycles, 2-word 4 cycles, +1 for LOADA/STORA/CALL/RET/POP/PUSH
//   data access; each wait cycle adds 1.
// STRUCTURE
// - Shared package dcpu_pkg: opcode constants, state enum, flag bit indices (FLAG_Z..FLAG_V),
//   ALU op codes; also used by the assembler test harness.
// - One sub-module: dcpu_alu_p #(DATA_W) (pure comb: a, b, op -> res, flags).
// - FSM, pc/sp/acc/ir/op registers and handshake driver live in this module.
// TESTING
// - Reset: rst pulse mid-FETCH with mem_req=1 -> mem_req=0 same cycle, pc=0, sp=254, acc=0, halted=0.
// - Arith/flags: LITA 0x7FFF; ADD 1 -> acc=0x8000, N=1,V=1,C=0,Z=0; CMP 0x8000 -> Z=1,C=1, acc kept.
// - Wait states: mem_ack delayed 0..5 random cycles on every access -> same final state as zero-wait run;
//   addr/we/wdata stable whenever req=1&ack=0.
// - Stack: LITA 5; PUSH; LITA 0; POP -> write M[254]=5, sp 252, then read M[254], acc=5, sp=254.
// - CALL/RET: CALL 0x40 at pc=0x10 -> M[254]=0x14, pc=0x40; RET -> pc=0x14, sp=254.
// - Branches/halt: CMP gives C=0 -> JMPC not taken (pc+4), JMPNC taken; opcode 0xff -> halted=1,
//   illegal=1, no further mem_req; STOP -> halted=1, illegal=0.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared definitions for the dCPU family: opcode encodings, FSM states,
// flag bit positions and ALU operation codes.
package dcpu_pkg;

  localparam logic [7:0] OP_LITA  = 8'hC0;
  localparam logic [7:0] OP_LOADA = 8'hC1;
  localparam logic [7:0] OP_STORA = 8'hC2;
  localparam logic [7:0] OP_ADD   = 8'hC3;
  localparam logic [7:0] OP_JMP   = 8'hC4;
  localparam logic [7:0] OP_JMPZ  = 8'hC5;
  localparam logic [7:0] OP_JMPC  = 8'hC6;
  localparam logic [7:0] OP_SUB   = 8'hC7;
  localparam logic [7:0] OP_CMP   = 8'hC8;
  localparam logic [7:0] OP_JMPNC = 8'hC9;
  localparam logic [7:0] OP_PUSH  = 8'hCA;
  localparam logic [7:0] OP_POP   = 8'hCB;
  localparam logic [7:0] OP_STOP  = 8'hCC;
  localparam logic [7:0] OP_CALL  = 8'hCD;
  localparam logic [7:0] OP_RET   = 8'hCE;
  localparam logic [7:0] OP_NOP   = 8'h90;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_OPND   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_SUB  = 2'd1,
    ALU_PASS = 2'd2
  } alu_op_t;

  // Defined opcodes are the contiguous C0..CE block plus NOP.
  function automatic logic is_defined(input logic [7:0] opc);
    return (opc == OP_NOP) || ((opc >= OP_LITA) && (opc <= OP_RET));
  endfunction

  function automatic logic is_one_word(input logic [7:0] opc);
    return (opc == OP_NOP) || (opc == OP_STOP) || (opc == OP_PUSH) ||
           (opc == OP_POP) || (opc == OP_RET);
  endfunction

endpackage

// File: rtl/dcpu_alu_p.sv
// Combinational ALU for the dCPU core: add/subtract with {V,N,C,Z} flags.
// For subtraction C means "no borrow" (a >= b unsigned).
module dcpu_alu_p
  import dcpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] res,
  output logic [3:0]        flags
);

  logic [DATA_W:0] wide;
  logic            ovf;

  always_comb begin
    wide = '0;
    ovf  = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        ovf  = (a[DATA_W-1] == b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        wide = {1'b0, a} - {1'b0, b};
        ovf  = (a[DATA_W-1] != b[DATA_W-1]) && (wide[DATA_W-1] != a[DATA_W-1]);
      end
      default: wide = {1'b0, b};
    endcase
    res           = wide[DATA_W-1:0];
    flags         = '0;
    flags[FLAG_Z] = (wide[DATA_W-1:0] == '0);
    flags[FLAG_N] = wide[DATA_W-1];
    // The extra bit is a borrow on subtract, so invert it to get "no borrow".
    flags[FLAG_C] = (op == ALU_SUB) ? ~wide[DATA_W] : wide[DATA_W];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/dcpu_core_hs.sv
// Parametrised accumulator CPU core with a req/ack memory port tolerating
// arbitrary wait states; halts on STOP or on an undefined opcode.
module dcpu_core_hs
  import dcpu_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int IB       = 2,
  parameter int PC_START = 0,
  parameter int SP_START = 254
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic              illegal,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] acc_dbg
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(IB);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] sp_reg, sp_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] op_reg, op_next;
  logic [7:0]        ir_reg, ir_next;
  logic [3:0]        flags_reg, flags_next;
  logic              req_reg, req_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              halted_reg, halted_next;
  logic              illegal_reg, illegal_next;

  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] op_addr;
  logic              launch_fetch;
  alu_op_t           alu_op;
  logic [DATA_W-1:0] alu_res;
  logic [3:0]        alu_flags;

  assign pc_seq  = pc_reg + (is_one_word(ir_reg) ? STEP : (STEP << 1));
  assign op_addr = ADDR_W'(op_reg);
  assign alu_op  = ((ir_reg == OP_SUB) || (ir_reg == OP_CMP)) ? ALU_SUB : ALU_ADD;

  dcpu_alu_p #(.DATA_W(DATA_W)) u_alu (
    .a     (acc_reg),
    .b     (op_reg),
    .op    (alu_op),
    .res   (alu_res),
    .flags (alu_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= ADDR_W'(PC_START);
      sp_reg      <= ADDR_W'(SP_START);
      acc_reg     <= '0;
      op_reg      <= '0;
      ir_reg      <= '0;
      flags_reg   <= '0;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      sp_reg      <= sp_next;
      acc_reg     <= acc_next;
      op_reg      <= op_next;
      ir_reg      <= ir_next;
      flags_reg   <= flags_next;
      req_reg     <= req_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      halted_reg  <= halted_next;
      illegal_reg <= illegal_next;
    end
  end

  // Requests are registered: the edge that leaves one state loads the next
  // transaction, so req/addr/we/wdata only change on an acknowledged edge.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    sp_next      = sp_reg;
    acc_next     = acc_reg;
    op_next      = op_reg;
    ir_next      = ir_reg;
    flags_next   = flags_reg;
    req_next     = req_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    halted_next  = halted_reg;
    illegal_next = illegal_reg;
    launch_fetch = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        if (!req_reg) begin
          // Only reached straight after reset.
          req_next  = 1'b1;
          we_next   = 1'b0;
          addr_next = pc_reg;
        end else if (mem_ack) begin
          ir_next    = mem_rdata[7:0];
          req_next   = 1'b0;
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (!is_defined(ir_reg)) begin
          halted_next  = 1'b1;
          illegal_next = 1'b1;
          state_next   = ST_HALT;
        end else if (!is_one_word(ir_reg)) begin
          req_next   = 1'b1;
          we_next    = 1'b0;
          addr_next  = pc_reg + STEP;
          state_next = ST_OPND;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_OPND: begin
        if (mem_ack) begin
          op_next    = mem_rdata;
          req_next   = 1'b0;
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        pc_next      = pc_seq;
        launch_fetch = 1'b1;
        case (ir_reg)
          OP_LITA: acc_next = op_reg;
          OP_ADD, OP_SUB: begin
            acc_next   = alu_res;
            flags_next = alu_flags;
          end
          OP_CMP:   flags_next = alu_flags;
          OP_JMP:   pc_next = op_addr;
          OP_JMPZ:  if (flags_reg[FLAG_Z]) pc_next = op_addr;
          OP_JMPC:  if (flags_reg[FLAG_C]) pc_next = op_addr;
          OP_JMPNC: if (!flags_reg[FLAG_C]) pc_next = op_addr;
          OP_LOADA, OP_STORA: begin
            launch_fetch = 1'b0;
            req_next     = 1'b1;
            we_next      = (ir_reg == OP_STORA);
            addr_next    = op_addr;
            wdata_next   = acc_reg;
            state_next   = ST_MEM;
          end
          OP_PUSH, OP_CALL: begin
            launch_fetch = 1'b0;
            req_next     = 1'b1;
            we_next      = 1'b1;
            addr_next    = sp_reg;
            wdata_next   = (ir_reg == OP_CALL) ? DATA_W'(pc_seq) : acc_reg;
            sp_next      = sp_reg - STEP;
            if (ir_reg == OP_CALL) pc_next = op_addr;
            state_next   = ST_MEM;
          end
          OP_POP, OP_RET: begin
            launch_fetch = 1'b0;
            req_next     = 1'b1;
            we_next      = 1'b0;
            addr_next    = sp_reg + STEP;
            sp_next      = sp_reg + STEP;
            state_next   = ST_MEM;
          end
          OP_STOP: begin
            launch_fetch = 1'b0;
            pc_next      = pc_reg;
            halted_next  = 1'b1;
            state_next   = ST_HALT;
          end
          default: ;
        endcase
        if (launch_fetch) state_next = ST_FETCH;
      end

      ST_MEM: begin
        if (mem_ack) begin
          launch_fetch = 1'b1;
          state_next   = ST_FETCH;
          if ((ir_reg == OP_LOADA) || (ir_reg == OP_POP)) acc_next = mem_rdata;
          if (ir_reg == OP_RET) pc_next = ADDR_W'(mem_rdata);
        end
      end

      default: begin
        req_next   = 1'b0;
        state_next = ST_HALT;
      end
    endcase

    if (launch_fetch) begin
      req_next  = 1'b1;
      we_next   = 1'b0;
      addr_next = pc_next;
    end
  end

  assign mem_req   = req_reg;
  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign halted    = halted_reg;
  assign illegal   = illegal_reg;
  assign flags     = flags_reg;
  assign acc_dbg   = acc_reg;

endmodule
